// File: rtl/bootstream_pkg.sv
// bootstream_pkg: shared definitions for the boot image SD reader.
//   state_t : 4-bit FSM encoding, also exported on o_state for debug.
//   field_t : which boot record field the parser is currently consuming.
//   EOF_MARKER, FIELD_HDR_BYTES : record format constants.
package bootstream_pkg;

    typedef enum logic [3:0] {
        ST_WAIT_CARD = 4'd0,
        ST_FETCH     = 4'd1,
        ST_FILL      = 4'd2,
        ST_ANNOUNCE  = 4'd3,
        ST_GAP       = 4'd4,
        ST_SERVE     = 4'd5,
        ST_READ_RAM  = 4'd6,
        ST_DELIVER   = 4'd7,
        ST_HOLD      = 4'd8,
        ST_EOF       = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        FLD_BLOCK = 2'd0,
        FLD_LEN   = 2'd1,
        FLD_DATA  = 2'd2
    } field_t;

    localparam logic [31:0] EOF_MARKER      = 32'hFFFF_FFFF;
    localparam int          FIELD_HDR_BYTES = 4;

endpackage

// File: rtl/bootstream_sd_reader_sector_buffer.sv
// sector_buffer: DEPTH x 8 simple dual-port RAM holding one SD sector.
//   clk          : clock
//   we/waddr/wdata : write port (sector fill side)
//   re/raddr     : synchronous read request
//   rdata        : read data, valid the cycle after re
module sector_buffer #(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/bootstream_sd_reader.sv
// bootstream_sd_reader: pulls SD sectors into a local buffer, parses the boot
// image records ([4B block][4B length L][L bytes], big-endian, block
// 0xFFFFFFFF ends the image) and serves bytes on the bootloader handshake.
//
// Ports:
//   clk, reset_n            : clock, async active-low reset
//   i_sd_ready              : card initialised
//   o_sd_rd_req/o_sd_sector : one-cycle sector read request + address
//   i_sd_byte_valid/i_sd_byte : sector byte stream (no backpressure)
//   i_sd_err                : reader error, forces eof with o_error
//   i_spi_byte              : active-low byte request from the bootloader
//   o_spi_start             : level, first sector buffered
//   o_spi_comm              : one-cycle field-announce pulse
//   o_spi_done/o_spi_data   : byte delivered pulse + held byte
//   o_spi_eof, o_error      : sticky end of image / error-caused end
//   o_checksum              : sum of DATA bytes (BOOTSTREAM_CHECKSUM_EN), else 0
//   o_state                 : FSM state for debug
//
// Build option: define BOOTSTREAM_CHECKSUM_EN to build the checksum adder.
module bootstream_sd_reader
    import bootstream_pkg::*;
#(
    parameter logic [31:0] START_SECTOR = 32'd0,
    parameter logic [31:0] MAX_SECTORS  = 32'd4096,
    parameter int          SECTOR_BYTES = 512,
    parameter int          COMM_GAP     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_sd_ready,
    output logic        o_sd_rd_req,
    output logic [31:0] o_sd_sector,
    input  logic        i_sd_byte_valid,
    input  logic [7:0]  i_sd_byte,
    input  logic        i_sd_err,
    input  logic        i_spi_byte,
    output logic        o_spi_start,
    output logic        o_spi_comm,
    output logic        o_spi_done,
    output logic        o_spi_eof,
    output logic [7:0]  o_spi_data,
    output logic        o_error,
    output logic [31:0] o_checksum,
    output logic [3:0]  o_state
);

    localparam int          AW         = $clog2(SECTOR_BYTES);
    localparam int          GW         = $clog2(COMM_GAP + 1);
    localparam logic [31:0] END_SECTOR = START_SECTOR + MAX_SECTORS;
    localparam logic [1:0]  HDR_LAST   = 2'(FIELD_HDR_BYTES - 1);

    state_t          state, state_n;
    // State to continue in once the current byte's handshake (and any
    // sector refill it triggered) completes; chosen by the record parser.
    state_t          resume_st;
    logic [31:0]     sector;
    logic [AW-1:0]   fill_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            last_byte;      // byte in flight is the last one buffered
    field_t          field;
    logic [1:0]      field_cnt;
    logic [23:0]     field_sr;       // first three header bytes, MSB first
    logic [31:0]     field_word;
    logic [31:0]     len_q;
    logic [31:0]     data_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            start_q, eof_q, err_q;
    logic [7:0]      data_q;

    logic            rd_req, comm, done;
    logic            ram_we, ram_re;
    logic [7:0]      ram_rdata;
    logic            err_hit;

    assign field_word = {field_sr, data_q};
    assign err_hit    = i_sd_err && (state != ST_WAIT_CARD) && (state != ST_EOF);

    sector_buffer #(
        .DEPTH (SECTOR_BYTES),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (ram_we),
        .waddr (fill_ptr),
        .wdata (i_sd_byte),
        .re    (ram_re),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_n = state;
        rd_req  = 1'b0;
        comm    = 1'b0;
        done    = 1'b0;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        case (state)
            ST_WAIT_CARD: if (i_sd_ready) state_n = ST_FETCH;
            ST_FETCH: begin
                rd_req  = 1'b1;
                state_n = ST_FILL;
            end
            ST_FILL: begin
                if (i_sd_byte_valid) begin
                    ram_we = 1'b1;
                    if (fill_ptr == '1)
                        state_n = resume_st;
                end
            end
            ST_ANNOUNCE: begin
                comm    = 1'b1;
                state_n = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt == GW'(COMM_GAP - 1)) begin
                    // Empty DATA field: nothing to serve, announce next BLOCK.
                    if (field == FLD_DATA && len_q == 32'd0)
                        state_n = ST_ANNOUNCE;
                    else
                        state_n = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (!i_spi_byte) begin
                    ram_re  = 1'b1;
                    state_n = ST_READ_RAM;
                end
            end
            ST_READ_RAM: state_n = ST_DELIVER;
            ST_DELIVER: begin
                done    = 1'b1;
                state_n = ST_HOLD;
            end
            ST_HOLD: begin
                // Wait for the request to be released so a held-low request
                // is served exactly once.
                if (i_spi_byte) begin
                    if (resume_st == ST_EOF)
                        state_n = ST_EOF;
                    else if (last_byte)
                        state_n = (sector == END_SECTOR) ? ST_EOF : ST_FETCH;
                    else
                        state_n = resume_st;
                end
            end
            ST_EOF: state_n = ST_EOF;
            default: state_n = ST_WAIT_CARD;
        endcase
        if (err_hit)
            state_n = ST_EOF;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_WAIT_CARD;
            resume_st <= ST_ANNOUNCE;
            sector    <= START_SECTOR;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            last_byte <= 1'b0;
            field     <= FLD_BLOCK;
            field_cnt <= 2'd0;
            field_sr  <= 24'd0;
            len_q     <= 32'd0;
            data_cnt  <= 32'd0;
            gap_cnt   <= '0;
            start_q   <= 1'b0;
            eof_q     <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= 8'd0;
        end else begin
            state <= state_n;

            if (ram_we) begin
                fill_ptr <= fill_ptr + 1'b1;
                if (fill_ptr == '1)
                    start_q <= 1'b1;
            end

            if (state == ST_ANNOUNCE)
                gap_cnt <= '0;
            else if (state == ST_GAP)
                gap_cnt <= gap_cnt + 1'b1;

            if (ram_re) begin
                rd_ptr    <= rd_ptr + 1'b1;
                last_byte <= (rd_ptr == '1);
            end

            if (state == ST_READ_RAM)
                data_q <= ram_rdata;

            if (state == ST_GAP && state_n == ST_ANNOUNCE) begin
                field     <= FLD_BLOCK;
                field_cnt <= 2'd0;
            end

            if (state == ST_DELIVER) begin
                if (last_byte)
                    sector <= sector + 32'd1;
                case (field)
                    FLD_DATA: begin
                        data_cnt <= data_cnt + 32'd1;
                        if (data_cnt + 32'd1 == len_q) begin
                            field     <= FLD_BLOCK;
                            field_cnt <= 2'd0;
                            resume_st <= ST_ANNOUNCE;
                        end else begin
                            resume_st <= ST_SERVE;
                        end
                    end
                    default: begin
                        field_sr <= field_word[23:0];
                        if (field_cnt == HDR_LAST) begin
                            field_cnt <= 2'd0;
                            if (field == FLD_BLOCK) begin
                                if (field_word == EOF_MARKER) begin
                                    resume_st <= ST_EOF;
                                end else begin
                                    field     <= FLD_LEN;
                                    resume_st <= ST_ANNOUNCE;
                                end
                            end else begin
                                len_q     <= field_word;
                                data_cnt  <= 32'd0;
                                field     <= FLD_DATA;
                                resume_st <= ST_ANNOUNCE;
                            end
                        end else begin
                            field_cnt <= field_cnt + 2'd1;
                            resume_st <= ST_SERVE;
                        end
                    end
                endcase
            end

            if (err_hit)
                err_q <= 1'b1;

            // Entering (or sitting in) EOF: only eof stays visible.
            if (state_n == ST_EOF) begin
                eof_q   <= 1'b1;
                start_q <= 1'b0;
                data_q  <= 8'd0;
            end
        end
    end

`ifdef BOOTSTREAM_CHECKSUM_EN
    logic [31:0] csum;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            csum <= 32'd0;
        else if (state == ST_DELIVER && field == FLD_DATA)
            csum <= csum + {24'd0, data_q};
    end
    assign o_checksum = csum;
`else
    assign o_checksum = 32'h0;
`endif

    assign o_sd_rd_req = rd_req;
    assign o_sd_sector = rd_req ? sector : 32'd0;
    assign o_spi_start = start_q;
    assign o_spi_comm  = comm;
    assign o_spi_done  = done;
    assign o_spi_eof   = eof_q;
    assign o_spi_data  = data_q;
    assign o_error     = err_q;
    assign o_state     = state;

endmodule

// File: tb/tb_bootstream_sd_reader.sv
// Scoreboard bench for bootstream_sd_reader with 16-byte sectors so that
// short images cross sector boundaries.
module tb_bootstream_sd_reader;

    localparam int SB  = 16;
    localparam int GAP = 4;
`ifdef BOOTSTREAM_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_sd_ready = 1'b0;
    logic        i_sd_byte_valid = 1'b0;
    logic [7:0]  i_sd_byte = 8'd0;
    logic        i_sd_err = 1'b0;
    logic        i_spi_byte = 1'b1;
    logic        o_sd_rd_req, o_spi_start, o_spi_comm, o_spi_done, o_spi_eof, o_error;
    logic [31:0] o_sd_sector, o_checksum;
    logic [7:0]  o_spi_data;
    logic [3:0]  o_state;

    always #5 clk = ~clk;

    bootstream_sd_reader #(
        .START_SECTOR (32'd0),
        .MAX_SECTORS  (32'd8),
        .SECTOR_BYTES (SB),
        .COMM_GAP     (GAP)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_sd_ready      (i_sd_ready),
        .o_sd_rd_req     (o_sd_rd_req),
        .o_sd_sector     (o_sd_sector),
        .i_sd_byte_valid (i_sd_byte_valid),
        .i_sd_byte       (i_sd_byte),
        .i_sd_err        (i_sd_err),
        .i_spi_byte      (i_spi_byte),
        .o_spi_start     (o_spi_start),
        .o_spi_comm      (o_spi_comm),
        .o_spi_done      (o_spi_done),
        .o_spi_eof       (o_spi_eof),
        .o_spi_data      (o_spi_data),
        .o_error         (o_error),
        .o_checksum      (o_checksum),
        .o_state         (o_state)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          n_done = 0;
    logic [7:0]  img [128];
    logic [7:0]  exp_q [$];
    int          comm_cyc [$];
    int          comm_dn [$];
    logic [31:0] sect_log [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on every delivered byte, log comms and sector requests.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (reset_n) begin
            if (o_sd_rd_req) sect_log.push_back(o_sd_sector);
            if (o_spi_comm) begin
                comm_cyc.push_back(cyc);
                comm_dn.push_back(n_done);
            end
            if (o_spi_done) begin
                n_done <= n_done + 1;
                if (exp_q.size() == 0)
                    chk("sb_underflow", 32'(exp_q.size()), 32'd1);
                else
                    chk("byte", {24'd0, o_spi_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // SD card model: stream the requested sector two cycles after the request.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && o_sd_rd_req) begin : serve_sector
                int base;
                base = int'(o_sd_sector) * SB;
                repeat (2) @(negedge clk);
                for (int i = 0; i < SB; i++) begin
                    i_sd_byte_valid = 1'b1;
                    i_sd_byte       = img[(base + i) % 128];
                    @(negedge clk);
                end
                i_sd_byte_valid = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load(input logic [7:0] b [$]);
        for (int i = 0; i < 128; i++) img[i] = 8'h00;
        for (int i = 0; i < b.size(); i++) img[i] = b[i];
    endtask

    task automatic do_reset();
        i_sd_ready = 1'b0;
        i_spi_byte = 1'b1;
        i_sd_err   = 1'b0;
        reset_n    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {14'd0, o_sd_rd_req, o_spi_start, o_spi_comm, o_spi_done,
                              o_spi_eof, o_error, o_spi_data, o_state}, 32'd0);
        chk("reset_sector", o_sd_sector, 32'd0);
        chk("reset_checksum", o_checksum, 32'd0);
        exp_q.delete();
        comm_cyc.delete();
        comm_dn.delete();
        sect_log.delete();
        reset_n = 1'b1;
        @(negedge clk);
        i_sd_ready = 1'b1;
    endtask

    // Bootloader model: pull one byte, optionally keep the request low.
    task automatic get_byte(input int hold, output int lat);
        int t;
        int extra;
        logic [7:0] d0;
        i_spi_byte = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!o_spi_done && t < 400);
        lat = t;
        if (!o_spi_done) begin
            chk("done_timeout", {31'd0, o_spi_done}, 32'd1);
        end else if (hold > 0) begin
            d0 = o_spi_data;
            extra = 0;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (o_spi_done) extra++;
            end
            chk("hold_extra_done", 32'(extra), 32'd0);
            chk("hold_data_stable", {24'd0, o_spi_data}, {24'd0, d0});
        end
        i_spi_byte = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_stream(input int nbytes, input int hold_idx, input int lat_idx);
        int lat;
        for (int k = 0; k < nbytes; k++) exp_q.push_back(img[k]);
        for (int k = 0; k < nbytes + 4 && !o_spi_eof; k++) begin
            get_byte((k == hold_idx) ? 20 : 0, lat);
            if (k == lat_idx) chk("latency", 32'(lat), 32'd2);
        end
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk("eof", {31'd0, o_spi_eof}, 32'd1);
        chk("no_error", {31'd0, o_error}, 32'd0);
    endtask

    initial begin
        int t;
        // T1: one 8-byte record then the end marker (marker bytes are served too).
        load('{8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h08,
               8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18,
               8'hFF, 8'hFF, 8'hFF, 8'hFF});
        do_reset();
        run_stream(20, 0, 10);
        chk("t1_comms", 32'(comm_cyc.size()), 32'd4);
        chk("t1_sector_reqs", 32'(sect_log.size()), 32'd2);
        if (sect_log.size() >= 1) chk("t1_first_sector", sect_log[0], 32'd0);
        chk("t1_checksum", o_checksum, CS_EN ? 32'h0000_00A4 : 32'd0);
        chk("t1_start_cleared", {31'd0, o_spi_start}, 32'd0);

        // T2: 12-byte record straddling the sector 0/1 boundary.
        load('{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C,
               8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28,
               8'h29, 8'h2A, 8'h2B, 8'h2C, 8'hFF, 8'hFF, 8'hFF, 8'hFF});
        do_reset();
        run_stream(24, -1, 17);
        chk("t2_sector_reqs", 32'(sect_log.size()), 32'd2);
        if (sect_log.size() >= 2) chk("t2_second_sector", sect_log[1], 32'd1);
        chk("t2_comms", 32'(comm_cyc.size()), 32'd4);
        chk("t2_checksum", o_checksum, CS_EN ? 32'h0000_01CE : 32'd0);

        // T3: L=0 record, then a record of four 0xFF, then the end marker.
        load('{8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h04,
               8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF});
        do_reset();
        run_stream(24, -1, -1);
        chk("t3_comms", 32'(comm_cyc.size()), 32'd7);
        if (comm_cyc.size() >= 4) begin
            chk("t3_empty_data_gap", 32'(comm_cyc[3] - comm_cyc[2]), 32'(GAP + 1));
            chk("t3_no_done_between", 32'(comm_dn[3] - comm_dn[2]), 32'd0);
        end
        chk("t3_checksum", o_checksum, CS_EN ? 32'h0000_03FC : 32'd0);

        // T4: reader error during the first fill, then reset and restart.
        do_reset();
        t = 0;
        while (!o_sd_rd_req && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("t4_fetch_seen", {31'd0, o_sd_rd_req}, 32'd1);
        repeat (4) @(negedge clk);
        i_sd_err = 1'b1;
        @(negedge clk);
        i_sd_err = 1'b0;
        @(negedge clk);
        chk("t4_eof", {31'd0, o_spi_eof}, 32'd1);
        chk("t4_error", {31'd0, o_error}, 32'd1);
        chk("t4_start_low", {31'd0, o_spi_start}, 32'd0);
        repeat (30) @(negedge clk);
        chk("t4_eof_sticky", {31'd0, o_spi_eof}, 32'd1);
        do_reset();
        t = 0;
        while (sect_log.size() == 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("t4_restart_req", 32'(sect_log.size()), 32'd1);
        if (sect_log.size() >= 1) chk("t4_restart_sector", sect_log[0], 32'd0);
        chk("t4_error_cleared", {31'd0, o_error}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
